// File: rtl/eth_dma_mem_responder.sv
// eth_dma_mem_responder: AXI4 burst slave memory with byte strobes serving the Ethernet DMA master.
module eth_dma_mem_responder #(
  parameter int dma_addr_bits = 64,
  parameter int dma_word_bits = 64,
  parameter int mem_words     = 1024,
  parameter logic [dma_addr_bits-1:0] base_addr = '0
) (
  input  logic                       clock,
  input  logic                       async_resetn,
  input  logic [dma_addr_bits-1:0]   s_axi_awaddr,
  input  logic [7:0]                 s_axi_awlen,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [dma_word_bits-1:0]   s_axi_wdata,
  input  logic [dma_word_bits/8-1:0] s_axi_wstrb,
  input  logic                       s_axi_wlast,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [dma_addr_bits-1:0]   s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [dma_word_bits-1:0]   s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready
);
  localparam int BPW = dma_word_bits / 8;
  localparam int OFF = $clog2(BPW);
  localparam int IW  = $clog2(mem_words);
  localparam logic [dma_addr_bits-1:0] MEM_BYTES = dma_addr_bits'(mem_words * BPW);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t r_wst, w_wst_nxt;
  r_state_t r_rst, w_rst_nxt;
  logic [dma_word_bits-1:0] r_mem [mem_words];
  logic [dma_addr_bits-1:0] w_aw_off, w_ar_off;
  logic [IW-1:0]            w_aw_idx, w_ar_idx, r_widx, r_ridx;
  logic                     w_aw_in, w_ar_in, w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic [7:0]               r_wcnt, r_rcnt;
  logic                     r_wok, r_werr, r_rok, r_rlast;
  logic [dma_word_bits-1:0] r_rdata;
  logic [1:0]               r_rresp;
  // Unsigned offset check also rejects addresses below base (they wrap to huge offsets).
  assign w_aw_off = s_axi_awaddr - base_addr;
  assign w_ar_off = s_axi_araddr - base_addr;
  assign w_aw_in  = w_aw_off < MEM_BYTES;
  assign w_ar_in  = w_ar_off < MEM_BYTES;
  assign w_aw_idx = w_aw_off[OFF +: IW];
  assign w_ar_idx = w_ar_off[OFF +: IW];
  assign w_aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_w_hs   = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
  assign w_r_hs   = s_axi_rready & s_axi_rvalid;
  assign s_axi_bresp = !r_wok ? 2'b11 : r_werr ? 2'b10 : 2'b00;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;
  assign s_axi_rlast = r_rlast;
  always_comb begin
    w_wst_nxt     = r_wst;
    w_rst_nxt     = r_rst;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_wst)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_wst_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && r_wcnt == 8'd0) w_wst_nxt = W_RESP;
      end
      default: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_wst_nxt = W_IDLE;
      end
    endcase
    case (r_rst)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) w_rst_nxt = R_DATA;
      end
      default: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && r_rcnt == 8'd0) w_rst_nxt = R_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_wst   <= W_IDLE;
      r_rst   <= R_IDLE;
      r_widx  <= '0;
      r_wcnt  <= '0;
      r_wok   <= 1'b1;
      r_werr  <= 1'b0;
      r_ridx  <= '0;
      r_rcnt  <= '0;
      r_rok   <= 1'b0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
      r_rlast <= 1'b0;
    end else begin
      r_wst <= w_wst_nxt;
      r_rst <= w_rst_nxt;
      if (w_aw_hs) begin
        r_widx <= w_aw_idx;
        r_wcnt <= s_axi_awlen;
        r_wok  <= w_aw_in;
        r_werr <= 1'b0;
      end else if (w_w_hs) begin
        r_widx <= r_widx + 1'b1;
        r_wcnt <= r_wcnt - 1'b1;
        r_werr <= r_werr | (s_axi_wlast != (r_wcnt == 8'd0));
      end
      // Next beat is fetched on the accepting edge so sustained rready gives one beat per cycle.
      if (w_ar_hs) begin
        r_ridx  <= w_ar_idx + 1'b1;
        r_rcnt  <= s_axi_arlen;
        r_rok   <= w_ar_in;
        r_rdata <= w_ar_in ? r_mem[w_ar_idx] : '0;
        r_rresp <= w_ar_in ? 2'b00 : 2'b11;
        r_rlast <= s_axi_arlen == 8'd0;
      end else if (w_r_hs) begin
        r_ridx  <= r_ridx + 1'b1;
        r_rcnt  <= r_rcnt - 1'b1;
        r_rdata <= r_rok ? r_mem[r_ridx] : '0;
        r_rlast <= r_rcnt == 8'd1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (w_w_hs && r_wok)
      for (int b = 0; b < BPW; b++)
        if (s_axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_eth_dma_mem_responder.sv
// tb_eth_dma_mem_responder: directed AXI bursts against eth_dma_mem_responder with hand-computed expectations.
module tb_eth_dma_mem_responder;
  logic        clock = 1'b0;
  logic        async_resetn;
  logic [63:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] wd [256];
  logic [63:0] ex [256];
  logic [1:0]  ex_resp;
  logic [7:0]  g_strb;
  int          early_last;
  logic [1:0]  resp;
  int          cyc;

  always #5 clock = ~clock;

  eth_dma_mem_responder dut (
    .clock(clock), .async_resetn(async_resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, 64'(s_axi_awready), 64'd1);
    chk({tag, "_arready"}, 64'(s_axi_arready), 64'd1);
    chk({tag, "_wready"},  64'(s_axi_wready),  64'd0);
    chk({tag, "_bvalid"},  64'(s_axi_bvalid),  64'd0);
    chk({tag, "_bresp"},   64'(s_axi_bresp),   64'd0);
    chk({tag, "_rvalid"},  64'(s_axi_rvalid),  64'd0);
    chk({tag, "_rdata"},   s_axi_rdata,        64'd0);
    chk({tag, "_rresp"},   64'(s_axi_rresp),   64'd0);
    chk({tag, "_rlast"},   64'(s_axi_rlast),   64'd0);
  endtask

  task automatic wr(input logic [63:0] a, input int len, input int bdelay, output logic [1:0] r);
    s_axi_awaddr = a; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
    chk("wr_awready_idle", 64'(s_axi_awready), 64'd1);
    step;
    s_axi_awvalid = 1'b0;
    chk("wr_wready_aw+1", 64'(s_axi_wready), 64'd1);
    chk("wr_awready_busy", 64'(s_axi_awready), 64'd0);
    for (int i = 0; i <= len; i++) begin
      chk("wr_wready_beat", 64'(s_axi_wready), 64'd1);
      s_axi_wdata = wd[i]; s_axi_wstrb = g_strb;
      s_axi_wlast = (i == len) || (i == early_last); s_axi_wvalid = 1'b1;
      step;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("wr_bvalid_u+1", 64'(s_axi_bvalid), 64'd1);
    for (int i = 0; i < bdelay; i++) begin
      step;
      chk("wr_bvalid_hold", 64'(s_axi_bvalid), 64'd1);
      chk("wr_awready_hold", 64'(s_axi_awready), 64'd0);
    end
    r = s_axi_bresp;
    s_axi_bready = 1'b1;
    step;
    s_axi_bready = 1'b0;
    chk("wr_bvalid_clr", 64'(s_axi_bvalid), 64'd0);
    chk("wr_awready_v+1", 64'(s_axi_awready), 64'd1);
  endtask

  task automatic rd(input logic [63:0] a, input int len, input bit toggle, output int c);
    int beat;
    s_axi_araddr = a; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
    chk("rd_arready_idle", 64'(s_axi_arready), 64'd1);
    step;
    s_axi_arvalid = 1'b0;
    chk("rd_rvalid_ar+1", 64'(s_axi_rvalid), 64'd1);
    chk("rd_arready_busy", 64'(s_axi_arready), 64'd0);
    beat = 0; c = 0;
    while (beat <= len && c < 2000) begin
      s_axi_rready = toggle ? (c % 2 == 0) : 1'b1;
      chk("rd_rvalid", 64'(s_axi_rvalid), 64'd1);
      chk("rd_rdata", s_axi_rdata, ex[beat]);
      chk("rd_rresp", 64'(s_axi_rresp), 64'(ex_resp));
      chk("rd_rlast", 64'(s_axi_rlast), 64'(beat == len));
      if (s_axi_rready) beat++;
      step;
      c++;
    end
    s_axi_rready = 1'b0;
    chk("rd_beats_done", 64'(beat), 64'(len + 1));
    chk("rd_rvalid_clr", 64'(s_axi_rvalid), 64'd0);
    chk("rd_arready_v+1", 64'(s_axi_arready), 64'd1);
  endtask

  initial begin
    async_resetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    g_strb = 8'hFF; early_last = -1; ex_resp = 2'b00;
    repeat (3) step;
    check_reset_outputs("reset");
    async_resetn = 1'b1;
    step;

    // single beat write then read
    wd[0] = 64'hDEADBEEF_CAFEF00D;
    wr(64'h10, 0, 0, resp);
    chk("single_bresp", 64'(resp), 64'd0);
    ex[0] = 64'hDEADBEEF_CAFEF00D;
    rd(64'h10, 0, 1'b0, cyc);
    chk("single_cycles", 64'(cyc), 64'd1);

    // 256-beat burst at word 256
    for (int i = 0; i < 256; i++) begin wd[i] = 64'(i); ex[i] = 64'(i); end
    wr(64'h800, 255, 0, resp);
    chk("burst_bresp", 64'(resp), 64'd0);
    rd(64'h800, 255, 1'b0, cyc);
    chk("burst_cycles", 64'(cyc), 64'd256);

    // byte strobes
    wd[0] = 64'h11223344_55667788;
    wr(64'h20, 0, 0, resp);
    wd[0] = 64'h0; g_strb = 8'h0F;
    wr(64'h20, 0, 0, resp);
    g_strb = 8'hFF;
    ex[0] = 64'h11223344_00000000;
    rd(64'h20, 0, 1'b0, cyc);

    // wrap from last word
    for (int i = 0; i < 4; i++) wd[i] = 64'hA0 + 64'(i);
    wr(64'h1FF8, 3, 0, resp);
    chk("wrap_bresp", 64'(resp), 64'd0);
    ex[0] = 64'hA0;
    rd(64'h1FF8, 0, 1'b0, cyc);
    for (int i = 0; i < 3; i++) ex[i] = 64'hA1 + 64'(i);
    rd(64'h0, 2, 1'b0, cyc);

    // out of range write/read
    for (int i = 0; i < 4; i++) wd[i] = 64'hBAD0 + 64'(i);
    wr(64'h2000, 3, 0, resp);
    chk("decerr_bresp", 64'(resp), 64'd3);
    rd(64'h0, 2, 1'b0, cyc);
    for (int i = 0; i < 4; i++) ex[i] = 64'h0;
    ex_resp = 2'b11;
    rd(64'h2000, 3, 1'b0, cyc);
    ex_resp = 2'b00;

    // early wlast
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hC0 + 64'(i); ex[i] = 64'hC0 + 64'(i); end
    early_last = 1;
    wr(64'h190, 3, 0, resp);
    early_last = -1;
    chk("slverr_bresp", 64'(resp), 64'd2);
    rd(64'h190, 3, 1'b0, cyc);

    // rready toggling
    for (int i = 0; i < 4; i++) ex[i] = 64'(i);
    rd(64'h800, 3, 1'b1, cyc);
    chk("toggle_cycles", 64'(cyc), 64'd7);

    // bready held low
    wd[0] = 64'hE1;
    wr(64'h300, 0, 5, resp);
    chk("bdelay_bresp", 64'(resp), 64'd0);

    // simultaneous read and write of one word
    s_axi_awaddr = 64'h300; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    step;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 64'hE2; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 64'h300; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    step;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    chk("conc_rvalid", 64'(s_axi_rvalid), 64'd1);
    chk("conc_old_data", s_axi_rdata, 64'hE1);
    chk("conc_bvalid", 64'(s_axi_bvalid), 64'd1);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    step;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    ex[0] = 64'hE2;
    rd(64'h300, 0, 1'b0, cyc);

    // reset in the middle of a read and an 8-beat write
    for (int i = 0; i < 8; i++) wd[i] = 64'h0;
    wr(64'h320, 7, 0, resp);
    s_axi_araddr = 64'h808; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
    step;
    s_axi_arvalid = 1'b0;
    chk("rst_pre_rdata", s_axi_rdata, 64'd1);
    s_axi_awaddr = 64'h320; s_axi_awlen = 8'd7; s_axi_awvalid = 1'b1;
    step;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axi_wdata = 64'hF0 + 64'(i); s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
      step;
    end
    s_axi_wvalid = 1'b0;
    chk("rst_pre_wready", 64'(s_axi_wready), 64'd1);
    #2 async_resetn = 1'b0;
    #1 check_reset_outputs("async_rst");
    step;
    async_resetn = 1'b1;
    step; step;
    chk("post_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("post_rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("post_rst_wready", 64'(s_axi_wready), 64'd0);
    ex[0] = 64'hF0; ex[1] = 64'hF1; ex[2] = 64'hF2; ex[3] = 64'h0;
    rd(64'h320, 3, 1'b0, cyc);
    wd[0] = 64'h77; wd[1] = 64'h78;
    wr(64'h340, 1, 0, resp);
    chk("post_rst_bresp", 64'(resp), 64'd0);
    ex[0] = 64'h77; ex[1] = 64'h78;
    rd(64'h340, 1, 1'b0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
